// File: rtl/adder_arb.sv
// Two-requester arbiter in front of one shared W-bit adder (IDLE -> CALC -> RESP).
// Define ADDER_ARB_RR_EN for round-robin arbitration; the default is fixed priority to requester 0.
module adder_arb #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W:0]   rsp_sum,
    output logic         rsp_id,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e       r_state;
    state_e       w_state_next;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_id;
    logic [W:0]   r_sum;
    logic         r_rsp_id;
    logic         w_grant0;
    logic         w_grant1;
    logic         w_accept;
    logic [W:0]   w_sum;

`ifdef ADDER_ARB_RR_EN
    logic r_ptr;

    // On conflict the requester not served last wins.
    always_comb begin
        w_grant1 = req1_valid & (~req0_valid | ~r_ptr);
        w_grant0 = req0_valid & ~w_grant1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b1;
        end else if (w_accept) begin
            r_ptr <= w_grant1;
        end
    end
`else
    always_comb begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid & ~req0_valid;
    end
`endif

    assign w_accept = (r_state == StIdle) & (w_grant0 | w_grant1);
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StCalc;
            StCalc:  w_state_next = StResp;
            StResp:  if (rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (r_state != StIdle);
        if (r_state == StIdle) begin
            req0_ready = w_grant0;
            req1_ready = w_grant1;
        end
        if (r_state == StResp) begin
            rsp_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= 1'b0;
            r_sum    <= '0;
            r_rsp_id <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= w_grant1 ? req1_a : req0_a;
                r_b  <= w_grant1 ? req1_b : req0_b;
                r_id <= w_grant1;
            end
            // Result and owner update together so they never disagree outside RESP.
            if (r_state == StCalc) begin
                r_sum    <= w_sum;
                r_rsp_id <= r_id;
            end
        end
    end

    assign rsp_sum = r_sum;
    assign rsp_id  = r_rsp_id;

endmodule
